// File: rtl/uart_pkg.sv
// Shared constants, state type and timing helper for the coordinate UART framer.
package uart_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 7;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} frame_state_t;

  // Ten bits per byte plus one guard bit, since the transmitter reports no busy state.
  function automatic int byte_clks(input int clk_freq, input int bps);
    return (clk_freq / bps) * 11;
  endfunction

endpackage

// File: rtl/uart_byte_pacer.sv
// Byte-time pacer: pulses done once BYTE_CLKS cycles have elapsed after start.
module uart_byte_pacer #(
  parameter int BYTE_CLKS = 110
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int CW = $clog2(BYTE_CLKS + 1);

  logic [CW-1:0] cnt;
  logic          running;

  assign done = running && (cnt == CW'(BYTE_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      running <= 1'b1;
    end else if (done) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/coord_uart_framer.sv
// Packs ball coordinates into a 7-byte frame and paces the bytes to the UART transmitter.
module coord_uart_framer
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         UART_BPS = 9600,
  parameter int         COORD_W  = 11,
  parameter logic [7:0] HEADER   = FRAME_HDR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coord_valid,
  input  logic [COORD_W-1:0] coord_x,
  input  logic [COORD_W-1:0] coord_y,
  input  logic               found,
  output logic [7:0]         tx_data,
  output logic               tx_trig,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  localparam int BYTE_CLKS = byte_clks(CLK_FREQ, UART_BPS);

  frame_state_t       state, next_state;
  logic [COORD_W-1:0] sh_x, sh_y, pend_x, pend_y;
  logic               sh_found, pend_found, pend_valid;
  logic [2:0]         byte_idx, send_idx;
  logic [7:0]         checksum, send_byte;
  logic [15:0]        x16, y16;
  logic               byte_done, last_byte;
  logic               take_pend, take_new, pend_write;

  assign x16       = 16'(sh_x);
  assign y16       = 16'(sh_y);
  assign last_byte = (byte_idx == 3'(FRAME_LEN - 1));
  assign tx_trig   = (state == SEND);
  assign busy      = (state != IDLE);

  uart_byte_pacer #(.BYTE_CLKS(BYTE_CLKS)) u_pacer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(state == SEND),
    .done (byte_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Pending has priority over a fresh strobe whenever a new frame is started.
  always_comb begin
    next_state = state;
    take_pend  = 1'b0;
    take_new   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          next_state = LOAD;
          take_pend  = 1'b1;
        end else if (coord_valid) begin
          next_state = LOAD;
          take_new   = 1'b1;
        end
      end
      LOAD: next_state = SEND;
      SEND: next_state = WAIT;
      WAIT: begin
        if (byte_done) begin
          if (!last_byte) begin
            next_state = SEND;
          end else if (pend_valid) begin
            next_state = LOAD;
            take_pend  = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign pend_write = coord_valid && !take_new;

  always_comb begin
    send_idx  = (state == LOAD) ? 3'd0 : byte_idx + 3'd1;
    send_byte = 8'h00;
    case (send_idx)
      3'd0:    send_byte = HEADER;
      3'd1:    send_byte = x16[15:8];
      3'd2:    send_byte = x16[7:0];
      3'd3:    send_byte = y16[15:8];
      3'd4:    send_byte = y16[7:0];
      3'd5:    send_byte = {7'b0, sh_found};
      3'd6:    send_byte = checksum;
      default: send_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x       <= '0;
      sh_y       <= '0;
      sh_found   <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_found <= 1'b0;
      pend_valid <= 1'b0;
      byte_idx   <= 3'd0;
      checksum   <= 8'h00;
      tx_data    <= 8'h00;
      drop_cnt   <= 8'h00;
    end else begin
      if (take_pend) begin
        sh_x     <= pend_x;
        sh_y     <= pend_y;
        sh_found <= pend_found;
      end else if (take_new) begin
        sh_x     <= coord_x;
        sh_y     <= coord_y;
        sh_found <= found;
      end

      if (state == LOAD) begin
        byte_idx <= 3'd0;
        checksum <= x16[15:8] + x16[7:0] + y16[15:8] + y16[7:0] + {7'b0, sh_found};
      end else if (state == WAIT && byte_done && !last_byte) begin
        byte_idx <= byte_idx + 3'd1;
      end

      if (next_state == SEND) tx_data <= send_byte;

      // A strobe landing in the same cycle pending is consumed refills it without a drop.
      if (pend_write) begin
        pend_x     <= coord_x;
        pend_y     <= coord_y;
        pend_found <= found;
        pend_valid <= 1'b1;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end

      if (pend_write && pend_valid && !take_pend && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
